execute_result_latch: RTL and testbench

EXECUTE_RESULT_LATCH -- requirements
Module: execute_result_latch

---
 rtl/execute_result_latch.sv | 152 +++++++++++++++
 tb/tb_execute_result_latch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_result_latch.sv
// Execute-stage result latch: registers ALU results, resolves bne/blt redirects and squashes younger slots.
// Define OVF_EXC_EN to turn signed overflow on add/addi/sub into an exception write to r30.
module execute_result_latch #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [2:0]  insn_kind,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_notequal,
  input  logic        alu_lessthan,
  input  logic [4:0]  rd_in,
  input  logic        we_in,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  output logic        out_we,
  output logic        out_exc,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        branch_taken,
  output logic [31:0] branch_pc,
  output logic        squash
);

  localparam logic [2:0] KIND_ADD   = 3'd0;
  localparam logic [2:0] KIND_ADDI  = 3'd1;
  localparam logic [2:0] KIND_SUB   = 3'd2;
  localparam logic [2:0] KIND_ALU   = 3'd3;
  localparam logic [2:0] KIND_BNE   = 3'd4;
  localparam logic [2:0] KIND_BLT   = 3'd5;
  localparam logic [2:0] KIND_NONE6 = 3'd6;
  localparam logic [2:0] KIND_NONE7 = 3'd7;
  localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_DEPTH);
  localparam logic [4:0] EXC_RD      = 5'd30;

`ifdef OVF_EXC_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        out_valid_r;
  logic        out_we_r;
  logic        out_exc_r;
  logic [31:0] out_result_r;
  logic [4:0]  out_rd_r;
  logic        branch_taken_r;
  logic [31:0] branch_pc_r;
  logic [1:0]  squash_cnt_r;

  logic        live_s;
  logic        is_arith_s;
  logic        is_branch_s;
  logic        no_result_s;
  logic        cond_s;
  logic        taken_s;
  logic        ovf_exc_s;
  logic [1:0]  squash_next_s;
  logic        next_we_s;
  logic        next_exc_s;
  logic [31:0] next_result_s;
  logic [4:0]  next_rd_s;

  // Decode the slot, resolve the branch and form the next register values.
  always_comb begin
    live_s        = in_valid && (squash_cnt_r == 2'd0);
    is_arith_s    = 1'b0;
    is_branch_s   = 1'b0;
    no_result_s   = 1'b0;
    cond_s        = 1'b0;
    squash_next_s = squash_cnt_r;
    next_we_s     = 1'b0;
    next_exc_s    = 1'b0;
    next_result_s = alu_result;
    next_rd_s     = rd_in;
    case (insn_kind)
      KIND_ADD, KIND_ADDI, KIND_SUB: is_arith_s = 1'b1;
      KIND_ALU: is_arith_s = 1'b0;
      KIND_BNE: begin
        is_branch_s = 1'b1;
        cond_s      = alu_notequal;
      end
      KIND_BLT: begin
        is_branch_s = 1'b1;
        cond_s      = alu_lessthan;
      end
      KIND_NONE6, KIND_NONE7: no_result_s = 1'b1;
      default: no_result_s = 1'b1;
    endcase
    taken_s   = live_s && cond_s;
    ovf_exc_s = OVF_EN && live_s && is_arith_s && alu_overflow;
    // A taken branch can only occur with the counter already at zero, so load wins.
    if (taken_s) begin
      squash_next_s = SQUASH_LOAD;
    end else if (squash_cnt_r != 2'd0) begin
      squash_next_s = squash_cnt_r - 2'd1;
    end else begin
      squash_next_s = 2'd0;
    end
    if (ovf_exc_s) begin
      next_we_s     = 1'b1;
      next_exc_s    = 1'b1;
      next_rd_s     = EXC_RD;
      next_result_s = {29'd0, insn_kind} + 32'd1;
    end else begin
      next_we_s     = live_s && we_in && !is_branch_s && !no_result_s;
      next_exc_s    = 1'b0;
      next_rd_s     = rd_in;
      next_result_s = alu_result;
    end
  end

  // Result, redirect and squash registers; stall freezes everything but drops the redirect pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r    <= 1'b0;
      out_we_r       <= 1'b0;
      out_exc_r      <= 1'b0;
      out_result_r   <= 32'd0;
      out_rd_r       <= 5'd0;
      branch_taken_r <= 1'b0;
      branch_pc_r    <= 32'd0;
      squash_cnt_r   <= 2'd0;
    end else if (stall) begin
      branch_taken_r <= 1'b0;
    end else begin
      out_valid_r    <= live_s;
      out_we_r       <= next_we_s;
      out_exc_r      <= next_exc_s;
      out_result_r   <= next_result_s;
      out_rd_r       <= next_rd_s;
      branch_taken_r <= taken_s;
      squash_cnt_r   <= squash_next_s;
      if (taken_s) begin
        branch_pc_r <= branch_target;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign out_we       = out_we_r;
  assign out_exc      = out_exc_r;
  assign out_result   = out_result_r;
  assign out_rd       = out_rd_r;
  assign branch_taken = branch_taken_r;
  assign branch_pc    = branch_pc_r;
  assign squash       = (squash_cnt_r != 2'd0);

endmodule

// File: tb/tb_execute_result_latch.sv
// Self-checking bench for execute_result_latch: directed vector table, hand-written
// stall/reset sequences, then random traffic against a slot-level reference model.
module tb_execute_result_latch;

  localparam int SQ = 2;

  logic        clock = 1'b0;
  logic        reset, in_valid, stall;
  logic [2:0]  insn_kind;
  logic [31:0] alu_result, branch_target;
  logic        alu_overflow, alu_notequal, alu_lessthan;
  logic [4:0]  rd_in;
  logic        we_in;
  logic        out_valid, out_we, out_exc, branch_taken, squash;
  logic [31:0] out_result, branch_pc;
  logic [4:0]  out_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_sq;
  logic        e_valid, e_we, e_exc, e_bt, e_known;
  logic [31:0] e_res, e_bpc;
  logic [4:0]  e_rd;

  typedef struct {
    logic        rst, stl, vld;
    logic [2:0]  kind;
    logic [31:0] res;
    logic        ovf, ne, lt;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] tgt;
    logic        x_valid, x_we, x_exc, x_bt, x_sq;
    logic [31:0] x_res;
    logic [4:0]  x_rd;
    logic [31:0] x_bpc;
    logic        chk;
  } vec_t;

  vec_t vecs[16];

  execute_result_latch #(.SQUASH_DEPTH(SQ)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .insn_kind(insn_kind), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_notequal(alu_notequal), .alu_lessthan(alu_lessthan), .rd_in(rd_in),
    .we_in(we_in), .branch_target(branch_target), .out_valid(out_valid),
    .out_we(out_we), .out_exc(out_exc), .out_result(out_result), .out_rd(out_rd),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .squash(squash)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic stl, input logic vld, input logic [2:0] kind,
                        input logic [31:0] res, input logic ovf, input logic ne, input logic lt,
                        input logic [4:0] rd, input logic we, input logic [31:0] tgt);
    reset = rst; stall = stl; in_valid = vld; insn_kind = kind; alu_result = res;
    alu_overflow = ovf; alu_notequal = ne; alu_lessthan = lt; rd_in = rd; we_in = we;
    branch_target = tgt;
  endtask

  // Advance the reference model by one clock edge using the applied inputs.
  task automatic model_step();
    logic live, is_br, taken;
    if (reset) begin
      m_sq = 0; e_valid = 1'b0; e_we = 1'b0; e_exc = 1'b0; e_bt = 1'b0;
      e_res = 32'd0; e_rd = 5'd0; e_bpc = 32'd0; e_known = 1'b1;
    end else if (stall) begin
      e_bt = 1'b0;
    end else begin
      live  = in_valid && (m_sq == 0);
      is_br = (insn_kind == 3'd4) || (insn_kind == 3'd5);
      taken = live && (((insn_kind == 3'd4) && alu_notequal) || ((insn_kind == 3'd5) && alu_lessthan));
      if (m_sq > 0) m_sq = m_sq - 1;
      if (taken) begin
        m_sq  = SQ;
        e_bpc = branch_target;
      end
      e_bt    = taken;
      e_valid = live;
      e_exc   = 1'b0;
      e_we    = live && we_in && !is_br && (insn_kind < 3'd6);
      e_res   = alu_result;
      e_rd    = rd_in;
      e_known = live;
`ifdef OVF_EXC_EN
      if (live && (insn_kind <= 3'd2) && alu_overflow) begin
        e_we = 1'b1; e_exc = 1'b1; e_rd = 5'd30;
        e_res = 32'(int'(insn_kind) + 1);
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".we"}, 32'(out_we), 32'(e_we));
    chk({tag, ".exc"}, 32'(out_exc), 32'(e_exc));
    chk({tag, ".bt"}, 32'(branch_taken), 32'(e_bt));
    chk({tag, ".squash"}, 32'(squash), 32'(m_sq != 0));
    chk({tag, ".bpc"}, branch_pc, e_bpc);
    if (e_known) begin
      chk({tag, ".result"}, out_result, e_res);
      chk({tag, ".rd"}, 32'(out_rd), 32'(e_rd));
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    m_sq = 0; e_known = 1'b0;

    //          rst   stl   vld   kind  res            ovf   ne    lt    rd     we    tgt          | valid we  exc   bt    sq    res           rd      bpc          chk
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h0,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h5,        1'b0, 1'b0, 1'b0, 5'd4,  1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5,        5'd4,  32'h0,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd9,  1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd9,  32'h0,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd6, 32'h7,        1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7,        5'd3,  32'h0,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd4, 32'h1,        1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,        5'd2,  32'h0,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'd4, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h40,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        5'd0,  32'h40, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h1,        1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0,  32'h40, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h2,        1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h40, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h8,        1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8,        5'd5,  32'h40, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'd5, 32'h0,        1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        5'd6,  32'h80, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'd5, 32'h0,        1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 32'hC0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0,  32'h80, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h3,        1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h80, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h4,        1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h80, 1'b0};
`ifdef OVF_EXC_EN
    vecs[13] = '{1'b0, 1'b0, 1'b1, 3'd2, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3,        5'd30, 32'h80, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd11, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1,        5'd30, 32'h80, 1'b1};
`else
    vecs[13] = '{1'b0, 1'b0, 1'b1, 3'd2, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234,     5'd7,  32'h80, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd11, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd11, 32'h80, 1'b1};
`endif
    vecs[14] = '{1'b0, 1'b0, 1'b1, 3'd5, 32'h9,        1'b0, 1'b1, 1'b0, 5'd8,  1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h9,        5'd8,  32'h80, 1'b1};

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].rst, vecs[i].stl, vecs[i].vld, vecs[i].kind, vecs[i].res, vecs[i].ovf,
             vecs[i].ne, vecs[i].lt, vecs[i].rd, vecs[i].we, vecs[i].tgt);
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].x_valid));
      chk($sformatf("vec%0d.we", i), 32'(out_we), 32'(vecs[i].x_we));
      chk($sformatf("vec%0d.exc", i), 32'(out_exc), 32'(vecs[i].x_exc));
      chk($sformatf("vec%0d.bt", i), 32'(branch_taken), 32'(vecs[i].x_bt));
      chk($sformatf("vec%0d.squash", i), 32'(squash), 32'(vecs[i].x_sq));
      chk($sformatf("vec%0d.bpc", i), branch_pc, vecs[i].x_bpc);
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d.result", i), out_result, vecs[i].x_res);
        chk($sformatf("vec%0d.rd", i), 32'(out_rd), 32'(vecs[i].x_rd));
      end
    end

    // stall for three cycles with the counter at its full depth
    set_in(1'b0, 1'b0, 1'b1, 3'd4, 32'h55, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 32'h200);
    tick();
    chk("stl.bt_pulse", 32'(branch_taken), 32'd1);
    chk("stl.bpc", branch_pc, 32'h200);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 3'd0, 32'h99, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h0);
      tick();
      chk($sformatf("stl%0d.bt", i), 32'(branch_taken), 32'd0);
      chk($sformatf("stl%0d.squash", i), 32'(squash), 32'd1);
      chk($sformatf("stl%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stl%0d.result", i), out_result, 32'h55);
      cmp_model($sformatf("stl%0d", i));
    end
    set_in(1'b0, 1'b0, 1'b1, 3'd0, 32'h11, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 32'h0);
    tick();
    chk("post1.valid", 32'(out_valid), 32'd0);
    chk("post1.squash", 32'(squash), 32'd1);
    tick();
    chk("post2.valid", 32'(out_valid), 32'd0);
    chk("post2.squash", 32'(squash), 32'd0);
    tick();
    chk("post3.valid", 32'(out_valid), 32'd1);
    chk("post3.result", out_result, 32'h11);

    // reset together with stall in the middle of a squash
    set_in(1'b0, 1'b0, 1'b1, 3'd5, 32'h66, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h300);
    tick();
    chk("rst.bt_pulse", 32'(branch_taken), 32'd1);
    set_in(1'b1, 1'b1, 1'b1, 3'd0, 32'h77, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h0);
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.we", 32'(out_we), 32'd0);
    chk("rst.exc", 32'(out_exc), 32'd0);
    chk("rst.bt", 32'(branch_taken), 32'd0);
    chk("rst.squash", 32'(squash), 32'd0);
    chk("rst.bpc", branch_pc, 32'd0);
    chk("rst.result", out_result, 32'd0);
    chk("rst.rd", 32'(out_rd), 32'd0);

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), $urandom(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom());
      tick();
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
